// File: rtl/dice_cgra_cfg_loader.sv
// dice_cgra_cfg_loader
//   Write side of the static CGRA configuration interface. A 32-bit valid/ready
//   word stream fills a shadow register word by word. When the last word has
//   been accepted, the shadow register is copied into cgra_cfg in one step.
//   The mesh therefore never sees a partially loaded bitstream.
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   cfg_start     pulse that begins a new load (honoured only when idle)
//   cfg_abort     abandons the current load; the committed config is kept
//   cfg_valid     stream word valid
//   cfg_ready     the loader accepts a word this cycle
//   cfg_data      stream word; word 0 lands in the LSBs (tile 0 low bits)
//   cgra_cfg      committed config; tile t = [t*TILE_CFG_W +: TILE_CFG_W]
//   cfg_busy      loader is not idle (registered)
//   cfg_done      1-cycle pulse in the first cycle the new cgra_cfg is visible
//   cfg_word_cnt  number of words accepted in the current/last load
module dice_cgra_cfg_loader #(
  parameter int TILE_CFG_W = 156,
  parameter int NUM_TILES  = 16,
  parameter int WORD_W     = 32,
  localparam int CFG_W     = TILE_CFG_W * NUM_TILES,
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic [CFG_W-1:0]  cgra_cfg,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [CNT_W-1:0]  cfg_word_cnt
);

  localparam int SHADOW_W = NUM_WORDS * WORD_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q;
  logic                accept;

  // Ready is derived from the state and the abort input only. It never depends
  // on cfg_valid, so the upstream side can wait for ready before asserting valid.
  assign cfg_ready = (state_q == LOAD) && !cfg_abort;
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start && !cfg_abort) state_d = LOAD;
      LOAD: begin
        if (cfg_abort)                             state_d = IDLE;
        else if (accept && cfg_word_cnt == LAST_CNT) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      cgra_cfg     <= '0;
      cfg_word_cnt <= '0;
      cfg_done     <= 1'b0;
      cfg_busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_busy <= (state_d != IDLE);
      cfg_done <= (state_q == COMMIT);

      if (state_q == IDLE && state_d == LOAD)
        cfg_word_cnt <= '0;
      else if (accept)
        cfg_word_cnt <= cfg_word_cnt + 1'b1;

      // Stream stage: the accepted word goes to its slot in the shadow register.
      if (accept)
        shadow_q[int'(cfg_word_cnt) * WORD_W +: WORD_W] <= cfg_data;

      // Commit stage: the copy into cgra_cfg is atomic. Shadow bits at or
      // above CFG_W are padding from the last word and are dropped here.
      if (state_q == COMMIT)
        cgra_cfg <= shadow_q[CFG_W-1:0];
    end
  end

endmodule
